// File: rtl/biquad_pkg.sv
// biquad_pkg: shared FSM states, history read-address encodings and width defaults for the biquad datapath
package biquad_pkg;
    typedef enum logic [1:0] {IDLE, LOADED, BUSY} state_t;
    localparam logic [1:0] SEL_X0 = 2'b00;
    localparam logic [1:0] SEL_XH = 2'b01;
    localparam logic [1:0] SEL_YH = 2'b10;
    localparam logic [1:0] DIR_N1 = 2'b00;
    localparam logic [1:0] DIR_N2 = 2'b01;
    localparam int DEFAULT_DATA_WIDTH = 16;
endpackage

// File: rtl/history_shift_reg.sv
// history_shift_reg: 2-deep shift register with sync clear; ports clk, reset, clear, shift, din -> q1 (n-1), q2 (n-2)
module history_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q1 <= '0;
            q2 <= '0;
        end else if (shift) begin
            q2 <= q1;
            q1 <= din;
        end
    end
endmodule

// File: rtl/biquad_history_writer.sv
// biquad_history_writer: holds x[n], shifts x/y history on commit, serves registered history reads
// ports: in_valid/in_data/in_ready sample handshake; frame_start, y_valid/y_data from sequencer and output reg;
//        rd_sel/rd_dir -> rd_data (1-cycle latency); flush clears history; sample_count; sticky seq_error
module biquad_history_writer
    import biquad_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  frame_start,
    input  logic [1:0]            rd_sel,
    input  logic [1:0]            rd_dir,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  y_valid,
    input  logic [DATA_WIDTH-1:0] y_data,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic                  seq_error
);
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] x0, x1, x2, y1, y2, rd_nx;
    logic accept, start, commit, bad;
    assign in_ready = (state == IDLE);
    // flush swallows every same-cycle event, including protocol checks
    always_comb begin
        accept   = !flush && in_valid && state == IDLE;
        start    = !flush && frame_start && !y_valid && state == LOADED;
        commit   = !flush && y_valid && !frame_start && state == BUSY;
        bad      = !flush && ((frame_start && (state != LOADED || y_valid)) ||
                              (y_valid && (state != BUSY || frame_start)));
        state_nx = flush ? IDLE : accept ? LOADED : start ? BUSY : commit ? IDLE : state;
        rd_nx    = rd_sel == SEL_X0 ? x0 :
                   rd_sel == SEL_XH && rd_dir == DIR_N1 ? x1 :
                   rd_sel == SEL_XH && rd_dir == DIR_N2 ? x2 :
                   rd_sel == SEL_YH && rd_dir == DIR_N1 ? y1 :
                   rd_sel == SEL_YH && rd_dir == DIR_N2 ? y2 : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            x0      <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= rd_nx;
            if (accept) x0 <= in_data;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_count <= '0;
            seq_error    <= 1'b0;
        end else begin
            if (commit) sample_count <= sample_count + 1'b1;
            if (bad)    seq_error    <= 1'b1;
        end
    end
    history_shift_reg #(.WIDTH(DATA_WIDTH)) u_x_hist (
        .clk(clk), .reset(reset), .clear(flush), .shift(commit), .din(x0), .q1(x1), .q2(x2)
    );
    history_shift_reg #(.WIDTH(DATA_WIDTH)) u_y_hist (
        .clk(clk), .reset(reset), .clear(flush), .shift(commit), .din(y_data), .q1(y1), .q2(y2)
    );
endmodule

// File: tb/tb_biquad_history_writer.sv
// tb_biquad_history_writer: scoreboard bench for the biquad history writer
module tb_biquad_history_writer;
    import biquad_pkg::*;
    localparam int W  = 16;
    localparam int CW = 16;
    logic clk = 1'b0;
    logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, frame_start = 1'b0, y_valid = 1'b0;
    logic [W-1:0] in_data = '0, y_data = '0, rd_data;
    logic [1:0] rd_sel = 2'b00, rd_dir = 2'b00;
    logic in_ready, seq_error;
    logic [CW-1:0] sample_count;
    int checks = 0, errors = 0;
    logic rd_go = 1'b0;
    logic [W-1:0] mx0, mx1, mx2, my1, my2, e;
    logic [CW-1:0] mcnt;
    logic [W-1:0] exp_q[$];

    biquad_history_writer #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .frame_start(frame_start), .rd_sel(rd_sel), .rd_dir(rd_dir),
        .rd_data(rd_data), .y_valid(y_valid), .y_data(y_data), .sample_count(sample_count),
        .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_read(input logic [1:0] s, input logic [1:0] d);
        case ({s, d})
            4'b0000, 4'b0001, 4'b0010, 4'b0011: return mx0;
            4'b0100: return mx1;
            4'b0101: return mx2;
            4'b1000: return my1;
            4'b1001: return my2;
            default: return '0;
        endcase
    endfunction

    // expected read value captured at the addressing edge, compared half a cycle later
    always @(posedge clk) if (rd_go) exp_q.push_back(model_read(rd_sel, rd_dir));
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                errors++;
                $display("FAIL read sel=%b dir=%b got=%h exp=%h t=%0t", rd_sel, rd_dir, rd_data, e, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] s, input logic [1:0] d);
        rd_sel = s;
        rd_dir = d;
        rd_go  = 1'b1;
        cyc();
        rd_go  = 1'b0;
    endtask

    task automatic read_all();
        rd(2'b00, 2'b00);
        rd(2'b01, 2'b00);
        rd(2'b01, 2'b01);
        rd(2'b10, 2'b00);
        rd(2'b10, 2'b01);
        rd(2'b11, 2'b00);
    endtask

    task automatic model_commit(input logic [W-1:0] y);
        mx2 = mx1; mx1 = mx0; my2 = my1; my1 = y; mcnt = mcnt + 1'b1;
    endtask

    task automatic do_reset();
        {flush, in_valid, frame_start, y_valid, rd_go} = '0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        {mx0, mx1, mx2, my1, my2} = '0;
        mcnt = '0;
    endtask

    task automatic frame(input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1; in_data = x;
        cyc();
        in_valid = 1'b0; mx0 = x;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        y_valid = 1'b1; y_data = y;
        cyc();
        y_valid = 1'b0;
        model_commit(y);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (sample_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error got=%b exp=0", seq_error); end
        read_all();
    endtask

    task automatic test_frames();
        frame(16'd100, 16'd10);
        frame(16'd200, 16'd20);
        frame(16'd300, 16'd30);
        checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL frames_count got=%0d exp=3", sample_count); end
        checks++; if (mx1 !== 16'd300 || my2 !== 16'd20) begin errors++; $display("FAIL frames_model got=%0d/%0d exp=300/20", mx1, my2); end
        read_all();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 16'd50;
        cyc();
        mx0 = 16'd50; in_data = 16'h7FFF;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_loaded_ready got=%b exp=0", in_ready); end
        frame_start = 1'b1;
        rd(SEL_X0, DIR_N1);
        frame_start = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_ready got=%b exp=0", in_ready); end
        rd(SEL_X0, DIR_N1);
        y_valid = 1'b1; y_data = 16'd60;
        cyc();
        y_valid = 1'b0;
        model_commit(16'd60);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready); end
        cyc();
        in_valid = 1'b0; mx0 = 16'h7FFF;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_ready got=%b exp=0", in_ready); end
        rd(SEL_X0, DIR_N1);
        rd(SEL_XH, DIR_N1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        y_valid = 1'b1; y_data = 16'd70;
        cyc();
        y_valid = 1'b0;
        model_commit(16'd70);
        checks++; if (sample_count !== mcnt) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", sample_count, mcnt); end
    endtask

    task automatic test_commit_read();
        in_valid = 1'b1; in_data = 16'd5;
        cyc();
        in_valid = 1'b0; mx0 = 16'd5;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        y_valid = 1'b1; y_data = 16'h8000;
        rd(SEL_YH, DIR_N1);
        y_valid = 1'b0;
        model_commit(16'h8000);
        rd(SEL_YH, DIR_N1);
        rd(SEL_YH, DIR_N2);
    endtask

    task automatic test_errors();
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL err_pre got=%b exp=0", seq_error); end
        y_valid = 1'b1; y_data = 16'h1234;
        cyc();
        y_valid = 1'b0;
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", seq_error); end
        checks++; if (sample_count !== mcnt) begin errors++; $display("FAIL err_count got=%0d exp=%0d", sample_count, mcnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL err_state got=%b exp=1", in_ready); end
        read_all();
        frame(16'd1, 16'd2);
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", seq_error); end
        read_all();
        do_reset();
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL err_reset got=%b exp=0", seq_error); end
    endtask

    task automatic test_flush();
        frame(16'd11, 16'd22);
        frame(16'd33, 16'd44);
        in_valid = 1'b1; in_data = 16'd55;
        cyc();
        in_valid = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        {mx0, mx1, mx2, my1, my2} = '0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL flush_rd_data got=%h exp=0", rd_data); end
        checks++; if (sample_count !== 16'd2) begin errors++; $display("FAIL flush_count got=%0d exp=2", sample_count); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL flush_err got=%b exp=0", seq_error); end
        read_all();
        y_valid = 1'b1; y_data = 16'd99;
        cyc();
        y_valid = 1'b0;
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL flush_yvalid_err got=%b exp=1", seq_error); end
        read_all();
    endtask

    initial begin
        test_reset();
        test_frames();
        test_backpressure();
        test_commit_read();
        test_errors();
        test_flush();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
